alu_ctrl_stage: RTL and testbench

Registered ALU-control stage between instruction decode and the Stage3 ALU block. Accepts decoded RV32I fields plus operand data through a valid/ready handshake. Classifies each instruction into the 2-bit ALU select that drives the ALU block's 2-to-4 enable decoder (ADD/ANDI/SRAI/XOR). Presents registered operands downstream through a 2-entry skid buffer, so IN_READY is a registered signal.

---
 rtl/alu_ctrl_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_stage.sv
// Registered ALU-control stage: decodes RV32I fields into the 2-bit ALU select and buffers through a 2-entry skid.
// Optional feature: define ALU_CTRL_ILLEGAL_EN to drop unsupported instructions and pulse illegal.
module alu_ctrl_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    input  logic [4:0]        rd_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              alu_in1,
    output logic              alu_in2,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [4:0]        rd_out,
    output logic              reg_we,
    output logic              illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_AND = 2'b01;
    localparam logic [1:0] SEL_SRA = 2'b10;
    localparam logic [1:0] SEL_XOR = 2'b11;

    typedef struct packed {
        logic [1:0]        sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        rd;
        logic              we;
    } entry_t;

    logic       dec_ok;
    logic [1:0] dec_sel;
    logic       dec_use_imm;
    logic       dec_we;

    always_comb begin
        dec_ok      = 1'b0;
        dec_sel     = SEL_ADD;
        dec_use_imm = 1'b1;
        dec_we      = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (!funct7b5 && funct3 == 3'b000) begin
                    dec_ok      = 1'b1;
                    dec_use_imm = 1'b0;
                end else if (!funct7b5 && funct3 == 3'b100) begin
                    dec_ok      = 1'b1;
                    dec_sel     = SEL_XOR;
                    dec_use_imm = 1'b0;
                end
            end
            OPC_OPIMM: begin
                case (funct3)
                    3'b000: dec_ok = 1'b1;
                    3'b111: begin
                        dec_ok  = 1'b1;
                        dec_sel = SEL_AND;
                    end
                    3'b101: begin
                        if (funct7b5) begin
                            dec_ok  = 1'b1;
                            dec_sel = SEL_SRA;
                        end
                    end
                    default: dec_ok = 1'b0;
                endcase
            end
            OPC_LOAD:  dec_ok = 1'b1;
            OPC_STORE: begin
                dec_ok = 1'b1;
                dec_we = 1'b0;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Unsupported instructions fall through as an add on IMM with no writeback.
    entry_t new_entry;
    assign new_entry.sel = dec_sel;
    assign new_entry.a   = rs1_data;
    assign new_entry.b   = dec_use_imm ? imm : rs2_data;
    assign new_entry.rd  = rd_addr;
    assign new_entry.we  = dec_we & dec_ok;

    entry_t main_q, skid_q, main_nxt, skid_nxt;
    logic   main_valid, skid_valid, main_valid_nxt, skid_valid_nxt;
    logic   illegal_q, illegal_nxt;
    logic   accept, drain, enq;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;

`ifdef ALU_CTRL_ILLEGAL_EN
    assign enq         = accept & dec_ok;
    assign illegal_nxt = accept & ~dec_ok & ~flush;
`else
    assign enq         = accept;
    assign illegal_nxt = 1'b0;
`endif

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        main_nxt       = main_q;
        skid_nxt       = skid_q;
        if (flush) begin
            main_valid_nxt = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_nxt       = skid_q;
                main_valid_nxt = 1'b1;
                skid_valid_nxt = 1'b0;
            end else begin
                main_valid_nxt = enq;
                if (enq) begin
                    main_nxt = new_entry;
                end
            end
        end else if (enq) begin
            skid_nxt       = new_entry;
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            illegal_q  <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            illegal_q  <= illegal_nxt;
        end
    end

    assign out_valid = main_valid;
    assign alu_in1   = main_q.sel[1];
    assign alu_in2   = main_q.sel[0];
    assign op_a      = main_q.a;
    assign op_b      = main_q.b;
    assign rd_out    = main_q.rd;
    assign reg_we    = main_q.we;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage with an expected-entry scoreboard; follows ALU_CTRL_ILLEGAL_EN if defined.
module tb_alu_ctrl_stage;

    localparam int CW = 72;
`ifdef ALU_CTRL_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        alu_in1;
    logic        alu_in2;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_out;
    logic        reg_we;
    logic        illegal;

    alu_ctrl_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd_addr(rd_addr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .op_a(op_a), .op_b(op_b),
        .rd_out(rd_out), .reg_we(reg_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    logic        cur_sup;
    logic        ill_exp;
    logic        hold_prev;
    logic [71:0] snap;
    int          n_run = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [4:0] rd, input logic [1:0] esel, input logic [31:0] eopb,
                         input logic ewe, input logic esup);
        in_valid     = 1'b1;
        opcode       = op;
        funct3       = f3;
        funct7b5     = b5;
        rs1_data     = a;
        rs2_data     = b;
        imm          = im;
        rd_addr      = rd;
        cur_exp.sel  = esel;
        cur_exp.op_a = a;
        cur_exp.op_b = eopb;
        cur_exp.rd   = rd;
        cur_exp.we   = ewe;
        cur_sup      = esup;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // One clock: check the scoreboard/illegal/stability at negedge, then step past the next posedge.
    task automatic cyc();
        exp_t e;
        logic [71:0] now_out;
        @(negedge clk);
        now_out = {alu_in1, alu_in2, op_a, op_b, rd_out, reg_we};
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", CW'(out_valid), CW'(0));
            end else begin
                e = sb.pop_front();
                chk("sb_sel", CW'({alu_in1, alu_in2}), CW'(e.sel));
                chk("sb_op_a", CW'(op_a), CW'(e.op_a));
                chk("sb_op_b", CW'(op_b), CW'(e.op_b));
                chk("sb_rd", CW'(rd_out), CW'(e.rd));
                chk("sb_we", CW'(reg_we), CW'(e.we));
            end
        end
        if (hold_prev && out_valid) begin
            chk("hold_stable", now_out, snap);
        end
        hold_prev = out_valid && !out_ready && !flush;
        snap      = now_out;
        chk("illegal_pulse", CW'(illegal), CW'(ill_exp));
        ill_exp = ILL_EN && in_valid && in_ready && !flush && !cur_sup;
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready && (cur_sup || !ILL_EN)) begin
            sb.push_back(cur_exp);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        rs1_data = '0; rs2_data = '0; imm = '0; rd_addr = '0; flush = 1'b0; out_ready = 1'b0;
        cur_exp = '0; cur_sup = 1'b1; ill_exp = 1'b0; hold_prev = 1'b0; snap = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", CW'(out_valid), CW'(0));
        chk("rst_sel", CW'({alu_in1, alu_in2}), CW'(0));
        chk("rst_op_a", CW'(op_a), CW'(0));
        chk("rst_op_b", CW'(op_b), CW'(0));
        chk("rst_rd", CW'(rd_out), CW'(0));
        chk("rst_we", CW'(reg_we), CW'(0));
        chk("rst_illegal", CW'(illegal), CW'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", CW'(in_ready), CW'(1));

        // Single ADD
        out_ready = 1'b1;
        drive(OP_R, 3'b000, 1'b0, 32'd5, 32'd7, 32'h99, 5'd3, 2'b00, 32'd7, 1'b1, 1'b1);
        cyc();
        idle();
        chk("add_valid", CW'(out_valid), CW'(1));
        chk("add_sel", CW'({alu_in1, alu_in2}), CW'(2'b00));
        chk("add_op_a", CW'(op_a), CW'(5));
        chk("add_op_b", CW'(op_b), CW'(7));
        chk("add_rd", CW'(rd_out), CW'(3));
        chk("add_we", CW'(reg_we), CW'(1));
        cyc();
        chk("add_drained", CW'(out_valid), CW'(0));

        // Back-to-back ANDI, SRAI, XOR, LOAD
        drive(OP_I, 3'b111, 1'b0, 32'd9, 32'd1, 32'h0F, 5'd1, 2'b01, 32'h0F, 1'b1, 1'b1);
        cyc();
        chk("andi_sel", CW'({alu_in1, alu_in2}), CW'(2'b01));
        chk("andi_op_b", CW'(op_b), CW'(32'h0F));
        drive(OP_I, 3'b101, 1'b1, 32'hF000_0000, 32'd1, 32'h404, 5'd2, 2'b10, 32'h404, 1'b1, 1'b1);
        cyc();
        chk("srai_sel", CW'({alu_in1, alu_in2}), CW'(2'b10));
        chk("srai_op_b", CW'(op_b), CW'(32'h404));
        drive(OP_R, 3'b100, 1'b0, 32'h5A, 32'hA5, 32'h1, 5'd7, 2'b11, 32'hA5, 1'b1, 1'b1);
        cyc();
        chk("xor_sel", CW'({alu_in1, alu_in2}), CW'(2'b11));
        chk("b2b_in_ready", CW'(in_ready), CW'(1));
        drive(OP_L, 3'b010, 1'b0, 32'h1000, 32'h7, 32'h10, 5'd8, 2'b00, 32'h10, 1'b1, 1'b1);
        cyc();
        idle();
        chk("load_valid", CW'(out_valid), CW'(1));
        cyc();
        chk("b2b_drained", CW'(out_valid), CW'(0));

        // Backpressure with three ADDIs
        out_ready = 1'b0;
        drive(OP_I, 3'b000, 1'b0, 32'd100, 32'd0, 32'd1, 5'd10, 2'b00, 32'd1, 1'b1, 1'b1);
        cyc();
        chk("bp_ready_after_1", CW'(in_ready), CW'(1));
        drive(OP_I, 3'b000, 1'b0, 32'd100, 32'd0, 32'd2, 5'd11, 2'b00, 32'd2, 1'b1, 1'b1);
        cyc();
        chk("bp_ready_drop", CW'(in_ready), CW'(0));
        drive(OP_I, 3'b000, 1'b0, 32'd100, 32'd0, 32'd3, 5'd12, 2'b00, 32'd3, 1'b1, 1'b1);
        cyc();
        cyc();
        chk("bp_stalled", CW'(in_ready), CW'(0));
        chk("bp_head_hold", CW'(op_b), CW'(1));
        out_ready = 1'b1;
        cyc();
        chk("bp_ready_rise", CW'(in_ready), CW'(1));
        chk("bp_second_head", CW'(op_b), CW'(2));
        cyc();
        idle();
        chk("bp_third_head", CW'(op_b), CW'(3));
        cyc();
        chk("bp_empty_valid", CW'(out_valid), CW'(0));
        chk("bp_sb_empty", CW'(sb.size()), CW'(0));

        // FLUSH with main and skid full plus a pending input
        out_ready = 1'b0;
        drive(OP_R, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1, 2'b00, 32'd2, 1'b1, 1'b1);
        cyc();
        drive(OP_R, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 5'd2, 2'b00, 32'd4, 1'b1, 1'b1);
        cyc();
        chk("fl_full", CW'(in_ready), CW'(0));
        drive(OP_R, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 5'd3, 2'b00, 32'd6, 1'b1, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("fl_valid", CW'(out_valid), CW'(0));
        chk("fl_ready", CW'(in_ready), CW'(1));
        out_ready = 1'b1;
        cyc();
        chk("fl_nothing_out", CW'(out_valid), CW'(0));

        // FLUSH with main full and a real same-cycle accept
        out_ready = 1'b0;
        drive(OP_R, 3'b000, 1'b0, 32'd7, 32'd8, 32'd0, 5'd4, 2'b00, 32'd8, 1'b1, 1'b1);
        cyc();
        chk("fl2_main", CW'(out_valid), CW'(1));
        drive(OP_R, 3'b000, 1'b0, 32'd9, 32'd10, 32'd0, 5'd5, 2'b00, 32'd10, 1'b1, 1'b1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("fl2_valid", CW'(out_valid), CW'(0));
        chk("fl2_ready", CW'(in_ready), CW'(1));
        out_ready = 1'b1;
        cyc();
        chk("fl2_nothing_out", CW'(out_valid), CW'(0));

        // Store, then unsupported opcode
        drive(OP_S, 3'b010, 1'b0, 32'h100, 32'hDEAD, 32'h8, 5'd0, 2'b00, 32'h8, 1'b0, 1'b1);
        cyc();
        chk("store_valid", CW'(out_valid), CW'(1));
        chk("store_we", CW'(reg_we), CW'(0));
        chk("store_sel", CW'({alu_in1, alu_in2}), CW'(2'b00));
        drive(OP_SYS, 3'b000, 1'b0, 32'h200, 32'h300, 32'h55, 5'd4, 2'b00, 32'h55, 1'b0, 1'b0);
        cyc();
        idle();
        chk("unsup_illegal", CW'(illegal), CW'(ILL_EN));
        chk("unsup_out_valid", CW'(out_valid), CW'(!ILL_EN));
        chk("unsup_we", CW'(reg_we), CW'(0));
        cyc();
        chk("unsup_pulse_end", CW'(illegal), CW'(0));
        chk("unsup_drained", CW'(out_valid), CW'(0));
        drive(OP_R, 3'b000, 1'b1, 32'h1, 32'h2, 32'h66, 5'd9, 2'b00, 32'h66, 1'b0, 1'b0);
        cyc();
        idle();
        chk("sub_illegal", CW'(illegal), CW'(ILL_EN));
        cyc();
        drive(OP_SYS, 3'b000, 1'b0, 32'h1, 32'h2, 32'h77, 5'd6, 2'b00, 32'h77, 1'b0, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush_suppresses_illegal", CW'(illegal), CW'(0));
        chk("flush_unsup_valid", CW'(out_valid), CW'(0));
        cyc();

        // Async reset with both entries full
        out_ready = 1'b0;
        drive(OP_R, 3'b000, 1'b0, 32'h11, 32'h22, 32'h0, 5'd5, 2'b00, 32'h22, 1'b1, 1'b1);
        cyc();
        drive(OP_R, 3'b100, 1'b0, 32'h33, 32'h44, 32'h0, 5'd6, 2'b11, 32'h44, 1'b1, 1'b1);
        cyc();
        idle();
        chk("ar_full", CW'(in_ready), CW'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", CW'(out_valid), CW'(0));
        chk("ar_sel", CW'({alu_in1, alu_in2}), CW'(0));
        chk("ar_op_a", CW'(op_a), CW'(0));
        chk("ar_op_b", CW'(op_b), CW'(0));
        chk("ar_rd", CW'(rd_out), CW'(0));
        chk("ar_we", CW'(reg_we), CW'(0));
        chk("ar_illegal", CW'(illegal), CW'(0));
        sb.delete();
        hold_prev = 1'b0;
        ill_exp   = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_in_ready", CW'(in_ready), CW'(1));
        chk("ar_valid_after", CW'(out_valid), CW'(0));
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("ar_no_replay", CW'(out_valid), CW'(0));
        chk("final_sb_empty", CW'(sb.size()), CW'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
